coin_session_ctrl: RTL
======================

# coin_session_ctrl

Session controller that sequences the coin-casher datapath of the arcade cabinet. It accumulates credit from validated coins and compares it with the game price. It starts the game and tells the casher when to eat the escrowed coins or spit them back, on return request or on insertion timeout. It sits between the coin acceptor front end and the game core, and owns the insertion timer the casher would otherwise need externally.

## Interface
- PRICE, 4: credit units needed per game; 1 ≤ PRICE ≤ 2^CREDIT_W−1
- CREDIT_W, 8: credit register width
- TIMEOUT_CYC, 1000: idle cycles in COLLECT before automatic refund; ≥ 2
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- coin_insert  in  1  one-cycle strobe: coin present on inserted_coin
- inserted_coin  in  3  coin code; 1..4 = value 1,2,5,10 units; 0,5,6,7 invalid
- return_coin  in  1  player refund button, level, sampled each cycle
- game_finish  in  1  one-cycle strobe from game core: game over
- wait_ready  out  1  high in IDLE: no credit, accepting coins
- game_active  out  1  high in PLAY
- game_start  out  1  one-cycle pulse in START
- eat_coins  out  1  one-cycle pulse in START: casher commits escrow
- spit_coin  out  1  one-cycle pulse in REFUND: casher returns escrow
- coin_reject  out  1  one-cycle pulse, cycle after a rejected coin
- credit  out  CREDIT_W  current credit, registered

## Operation
- States: IDLE, COLLECT, START, PLAY, REFUND. Outputs are Moore/registered.
- Coin accepted when code valid, state is IDLE or COLLECT, no return_coin that cycle, and credit+value ≤ 2^CREDIT_W−1. Otherwise coin_reject.
- IDLE: on accepted coin, credit ← value. Go START if value ≥ PRICE, else COLLECT.
- COLLECT: on accepted coin, credit ← credit+value. Go START if sum ≥ PRICE. return_coin → REFUND (return beats a same-cycle coin, which is rejected). Timeout → REFUND.
- START: one cycle, pulses game_start and eat_coins. Exits to PLAY with credit ← credit−PRICE (excess carried over).
- PLAY: every coin rejected, return_coin ignored. On game_finish: IDLE if credit = 0, else COLLECT (timer restarted).
- REFUND: one cycle, pulses spit_coin. Exits to IDLE with credit ← 0.
- Reset (any time, including mid-game): state IDLE, credit 0, wait_ready 1, every other output 0. Timer cleared. No spit is issued.

## Timing
- Coin strobe at cycle N → credit/state updated at N+1. coin_reject, if any, high exactly at N+1.
- Reaching PRICE at N → START at N+1 (game_start, eat_coins high) → PLAY and reduced credit at N+2.
- return_coin high at N in COLLECT → REFUND at N+1 → IDLE, credit 0 at N+2.
- Timer is cleared on entry to COLLECT and on each accepted coin, and increments each other COLLECT cycle. The transition to REFUND fires the cycle after the count reaches TIMEOUT_CYC−1.
- game_finish at N in PLAY → IDLE/COLLECT at N+1. A game_finish outside PLAY is ignored.

## Configuration
- COIN_TIMEOUT_EN defined: insertion timer instantiated, timeout refund active.
- Not defined: no timer logic. COLLECT waits indefinitely, and refund only via return_coin. TIMEOUT_CYC is ignored.

## Structure
- Shared package coin_pkg holds:
  - the state enum session_state_t;
  - the coin-code constants;
  - the function coin_value(code) returning a value and a valid flag.
- One sub-module, coin_timeout_timer (clear, enable, expire), wrapped by COIN_TIMEOUT_EN.

## Test plan
(PRICE=4, TIMEOUT_CYC=16, macro defined unless noted)
- Reset mid-PLAY with credit 3 → next cycle IDLE, credit 0, wait_ready 1, no spit_coin.
- Coins code 1 then code 2 (1+2 units), then code 1 → credit 1, 3, 4. START one cycle with game_start=eat_coins=1, then PLAY with credit 0. game_finish → IDLE.
- Single code 4 (10 units) in IDLE → START next cycle, PLAY with credit 6. game_finish → COLLECT, credit 6 → START again the next cycle.
- Code 2 then 16 idle cycles → REFUND with spit_coin one cycle, then IDLE, credit 0. With the macro undefined, 100 idle cycles leave the state in COLLECT with credit 2.
- Code 1 accepted, then coin code 2 and return_coin in the same cycle → coin_reject and REFUND the following cycle, then credit 0.
- Codes 0, 5, 7 in IDLE, and code 1 during PLAY → coin_reject pulse each, credit and state unchanged.

Source files
------------

// File: rtl/coin_pkg.sv
// Shared types for the coin session controller: session states,
// coin codes and the code-to-value decoder.
package coin_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_START,
        S_PLAY,
        S_REFUND
    } session_state_t;

    localparam logic [2:0] COIN_1  = 3'd1;
    localparam logic [2:0] COIN_2  = 3'd2;
    localparam logic [2:0] COIN_5  = 3'd3;
    localparam logic [2:0] COIN_10 = 3'd4;

    typedef struct packed {
        logic       valid;
        logic [3:0] value;
    } coin_val_t;

    function automatic coin_val_t coin_value(input logic [2:0] code);
        coin_val_t r;
        r.valid = 1'b1;
        r.value = 4'd0;
        case (code)
            COIN_1:  r.value = 4'd1;
            COIN_2:  r.value = 4'd2;
            COIN_5:  r.value = 4'd5;
            COIN_10: r.value = 4'd10;
            default: r.valid = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/coin_timeout_timer.sv
// Insertion timer: counts enabled cycles since the last clear and
// flags expiry once TIMEOUT_CYC-1 has been reached (built under COIN_TIMEOUT_EN).
module coin_timeout_timer #(
    parameter int unsigned TIMEOUT_CYC = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_last;

    assign w_last   = (r_cnt == LAST);
    assign o_expire = i_enable && w_last;

    // Saturates at LAST so a held expiry never wraps.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_enable && !w_last) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/coin_session_ctrl.sv
// Coin session sequencer: credit accumulation, game start/eat and refund/spit.
// Define COIN_TIMEOUT_EN to build the insertion timer and timeout refund.
module coin_session_ctrl
    import coin_pkg::*;
#(
    parameter int unsigned PRICE       = 4,
    parameter int unsigned CREDIT_W    = 8,
    parameter int unsigned TIMEOUT_CYC = 1000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                coin_insert,
    input  logic [2:0]          inserted_coin,
    input  logic                return_coin,
    input  logic                game_finish,
    output logic                wait_ready,
    output logic                game_active,
    output logic                game_start,
    output logic                eat_coins,
    output logic                spit_coin,
    output logic                coin_reject,
    output logic [CREDIT_W-1:0] credit
);

    localparam logic [CREDIT_W:0]   PRICE_X = (CREDIT_W + 1)'(PRICE);
    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);

    session_state_t      r_state;
    session_state_t      w_next;
    logic [CREDIT_W-1:0] r_credit;
    logic [CREDIT_W-1:0] w_credit_next;
    logic                r_reject;
    coin_val_t           w_coin;
    logic [CREDIT_W:0]   w_sum;
    logic [CREDIT_W:0]   w_total;
    logic                w_open;
    logic                w_accept;
    logic                w_expire;

    assign w_coin   = coin_value(inserted_coin);
    assign w_sum    = {1'b0, r_credit} + (CREDIT_W + 1)'(w_coin.value);
    assign w_open   = (r_state == S_IDLE) || (r_state == S_COLLECT);
    assign w_accept = coin_insert && w_coin.valid && !return_coin
                   && !w_sum[CREDIT_W] && w_open;
    assign w_total  = w_accept ? w_sum : {1'b0, r_credit};

`ifdef COIN_TIMEOUT_EN
    coin_timeout_timer #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .i_clear  ((r_state != S_COLLECT) || w_accept),
        .i_enable (r_state == S_COLLECT),
        .o_expire (w_expire)
    );
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYC != 0);
    assign w_expire         = 1'b0;
`endif

    always_comb begin
        w_next        = r_state;
        w_credit_next = r_credit;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_credit_next = w_total[CREDIT_W-1:0];
                    w_next = (w_total >= PRICE_X) ? S_START : S_COLLECT;
                end
            end
            S_COLLECT: begin
                // Return wins over any coin or pending credit this cycle.
                if (return_coin) begin
                    w_next = S_REFUND;
                end else begin
                    w_credit_next = w_total[CREDIT_W-1:0];
                    if (w_total >= PRICE_X) begin
                        w_next = S_START;
                    end else if (!w_accept && w_expire) begin
                        w_next = S_REFUND;
                    end
                end
            end
            S_START: begin
                w_next        = S_PLAY;
                w_credit_next = r_credit - PRICE_C;
            end
            S_PLAY: begin
                if (game_finish) begin
                    w_next = (r_credit == '0) ? S_IDLE : S_COLLECT;
                end
            end
            S_REFUND: begin
                w_next        = S_IDLE;
                w_credit_next = '0;
            end
            default: begin
                w_next        = S_IDLE;
                w_credit_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_credit <= '0;
            r_reject <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_credit <= w_credit_next;
            r_reject <= coin_insert && !w_accept;
        end
    end

    assign wait_ready  = (r_state == S_IDLE);
    assign game_active = (r_state == S_PLAY);
    assign game_start  = (r_state == S_START);
    assign eat_coins   = (r_state == S_START);
    assign spit_coin   = (r_state == S_REFUND);
    assign coin_reject = r_reject;
    assign credit      = r_credit;

endmodule
